// File: rtl/bsg_front_side_bus_hop_out.sv
// bsg_front_side_bus_hop_out
//
// Output side of one front-side-bus hop. Merges fan_in_p sources onto the
// next bus segment through a round-robin arbiter and a two-entry output
// buffer. Source 0 is traffic passing through from this hop's input stage;
// sources 1..fan_in_p-1 are injected locally.
//
// The buffer is fully registered on the output side and ready_and_o depends
// only on buffer occupancy, never on ready_and_i. This keeps every
// ready/valid path along the bus chain broken at each hop. The price is one
// bubble: a full buffer refuses a new word even in a cycle where it drains.
//
// Ports:
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   v_i          per-source valid
//   data_i       per-source payload, source i at [i*width_p +: width_p]
//   ready_and_o  per-source ready; source i transfers on v_i[i] & ready_and_o[i]
//   v_o          valid to the next hop
//   data_o       payload to the next hop
//   ready_and_i  ready from the next hop; transfer on v_o & ready_and_i

module bsg_front_side_bus_hop_out #(
    parameter int unsigned width_p  = 8,
    parameter int unsigned fan_in_p = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [fan_in_p-1:0]         v_i,
    input  logic [fan_in_p*width_p-1:0] data_i,
    output logic [fan_in_p-1:0]         ready_and_o,
    output logic                        v_o,
    output logic [width_p-1:0]          data_o,
    input  logic                        ready_and_i
);

    localparam int unsigned RrWidth = (fan_in_p > 1) ? $clog2(fan_in_p) : 1;

    // Buffer state
    logic [1:0]         count_q, count_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [width_p-1:0] mem_q [2];

    // Arbitration state
    logic [RrWidth-1:0] rr_q, rr_d;
    logic [RrWidth-1:0] grant;
    logic               found;

    logic               full;
    logic               enq;
    logic               deq;
    logic [width_p-1:0] enq_data;

    assign full = (count_q == 2'd2);
    assign v_o  = (count_q != 2'd0);
    assign deq  = v_o & ready_and_i;

    assign data_o = mem_q[rd_ptr_q];

    // Round-robin scan starting at rr_q, wrapping modulo fan_in_p.
    always_comb begin
        int unsigned        idx;
        logic [RrWidth-1:0] cand;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < fan_in_p; i++) begin
            idx  = (32'(rr_q) + i) % fan_in_p;
            cand = RrWidth'(idx);
            if (!found && v_i[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Ready is gated by reset so no source sees a ready while the hop is held.
    always_comb begin
        ready_and_o = '0;
        if (found && !full && reset_n_i) begin
            ready_and_o[grant] = 1'b1;
        end
    end

    assign enq = |(v_i & ready_and_o);

    // Payload mux for the granted source.
    always_comb begin
        enq_data = '0;
        for (int unsigned i = 0; i < fan_in_p; i++) begin
            if (RrWidth'(i) == grant) begin
                enq_data = data_i[i*width_p +: width_p];
            end
        end
    end

    // Next-state for pointers, occupancy and round-robin priority.
    always_comb begin
        int unsigned nxt;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rr_d     = rr_q;
        nxt      = 0;
        count_d  = count_q + {1'b0, enq} - {1'b0, deq};
        if (deq) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (enq) begin
            wr_ptr_d = ~wr_ptr_q;
            nxt      = (32'(grant) + 1) % fan_in_p;
            rr_d     = RrWidth'(nxt);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            rr_q     <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rr_q     <= rr_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= enq_data;
        end
    end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out.sv
module tb_bsg_front_side_bus_hop_out;

    localparam int W = 8;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset_n_i = 1'b0;
    logic [N-1:0]   v_i = '0;
    logic [N*W-1:0] data_i = '0;
    logic [N-1:0]   ready_and_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic           ready_and_i = 1'b0;

    int checks = 0;
    int errors = 0;

    bsg_front_side_bus_hop_out #(
        .width_p  (W),
        .fan_in_p (N)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n_i),
        .v_i         (v_i),
        .data_i      (data_i),
        .ready_and_o (ready_and_o),
        .v_o         (v_o),
        .data_o      (data_o),
        .ready_and_i (ready_and_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: FIFO of accepted words plus a priority index.
    logic [W-1:0] q[$];
    int           rr_m = 0;
    logic [N-1:0] acc_m = '0;

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (reset_n_i && q.size() < 2) begin
            for (int k = 0; k < N; k++) begin
                int s;
                s = (rr_m + k) % N;
                if (r == '0 && v_i[s]) r[s] = 1'b1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            q.delete();
            rr_m  = 0;
            acc_m = '0;
        end else begin
            logic [N-1:0] r;
            r     = exp_ready();
            acc_m = v_i & r;
            if (q.size() != 0 && ready_and_i) void'(q.pop_front());
            for (int s = 0; s < N; s++) begin
                if (acc_m[s]) begin
                    q.push_back(data_i[s*W +: W]);
                    rr_m = (s + 1) % N;
                end
            end
        end
    end

    // Every-cycle compare against the model, plus hold and starvation rules.
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;
    int           wait_c [N];

    initial for (int s = 0; s < N; s++) wait_c[s] = 0;

    always @(negedge clk) begin
        chk("ready_and_o", 32'(ready_and_o), 32'(exp_ready()));
        chk("v_o", 32'(v_o), 32'(q.size() != 0));
        if (q.size() != 0) chk("data_o", 32'(data_o), 32'(q[0]));
        if (!reset_n_i) begin
            prev_hold = 1'b0;
            for (int s = 0; s < N; s++) wait_c[s] = 0;
        end else begin
            logic [N-1:0] acc;
            if (prev_hold) begin
                chk("hold_v", 32'(v_o), 32'd1);
                chk("hold_data", 32'(data_o), 32'(prev_data));
            end
            prev_hold = v_o && !ready_and_i;
            prev_data = data_o;
            acc = v_i & ready_and_o;
            if (acc != '0) begin
                for (int s = 0; s < N; s++) begin
                    if (acc[s]) begin
                        wait_c[s] = 0;
                    end else if (v_i[s]) begin
                        wait_c[s]++;
                        chk("starve", 32'(wait_c[s] <= N - 1), 32'd1);
                    end else begin
                        wait_c[s] = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] outs[$];
    logic [W-1:0] d0, d1;
    logic [W-1:0] exp_seq [8];

    initial begin
        // Reset with both sources valid: ready must stay low.
        v_i = 2'b11;
        data_i = 16'h2211;
        repeat (2) @(negedge clk);
        chk("rst_v_o", 32'(v_o), 32'd0);
        chk("rst_ready", 32'(ready_and_o), 32'd0);
        step();
        v_i = 2'b00;
        reset_n_i = 1'b1;

        // Idle for five cycles.
        repeat (5) begin
            @(negedge clk);
            chk("idle_v_o", 32'(v_o), 32'd0);
            chk("idle_ready", 32'(ready_and_o), 32'd0);
            step();
        end

        // Single word from source 1.
        ready_and_i = 1'b1;
        v_i = 2'b10;
        data_i = 16'hA500;
        @(negedge clk);
        chk("src1_ready", 32'(ready_and_o), 32'h2);
        step();
        v_i = 2'b00;
        @(negedge clk);
        chk("src1_v", 32'(v_o), 32'd1);
        chk("src1_data", 32'(data_o), 32'hA5);
        step();
        @(negedge clk);
        chk("src1_once", 32'(v_o), 32'd0);
        step();

        // Both sources streaming, output never stalls.
        d0 = 8'h10;
        d1 = 8'h20;
        v_i = 2'b11;
        data_i = {d1, d0};
        repeat (10) begin
            @(negedge clk);
            if (v_o && ready_and_i) outs.push_back(data_o);
            step();
            if (acc_m[0]) d0++;
            if (acc_m[1]) d1++;
            data_i = {d1, d0};
        end
        v_i = 2'b00;
        exp_seq = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
        chk("stream_count", 32'(outs.size()), 32'd9);
        for (int i = 0; i < 8; i++) begin
            if (i < outs.size()) chk("stream_order", 32'(outs[i]), 32'(exp_seq[i]));
        end
        repeat (3) step();

        // Fill with output stalled, then drain.
        ready_and_i = 1'b0;
        v_i = 2'b01;
        data_i = 16'h0030;
        step();
        data_i = 16'h0031;
        step();
        data_i = 16'h0032;
        @(negedge clk);
        chk("full_ready", 32'(ready_and_o), 32'd0);
        chk("full_data", 32'(data_o), 32'h30);
        step();
        ready_and_i = 1'b1;
        @(negedge clk);
        chk("drain0_data", 32'(data_o), 32'h30);
        chk("drain0_ready", 32'(ready_and_o), 32'd0);
        step();
        @(negedge clk);
        chk("drain1_data", 32'(data_o), 32'h31);
        chk("drain1_ready", 32'(ready_and_o), 32'h1);
        step();
        v_i = 2'b00;
        @(negedge clk);
        chk("drain2_data", 32'(data_o), 32'h32);
        repeat (3) step();

        // Fill via source 0 (priority moves to 1), then reset mid-cycle.
        ready_and_i = 1'b0;
        v_i = 2'b01;
        data_i = 16'h0050;
        step();
        data_i = 16'h0051;
        step();
        v_i = 2'b00;
        @(negedge clk);
        chk("pre_rst_v", 32'(v_o), 32'd1);
        @(posedge clk);
        #3;
        reset_n_i = 1'b0;
        #1;
        chk("async_rst_v", 32'(v_o), 32'd0);
        step();
        step();
        reset_n_i = 1'b1;
        ready_and_i = 1'b1;
        v_i = 2'b11;
        data_i = 16'h7060;
        @(negedge clk);
        chk("post_rst_v", 32'(v_o), 32'd0);
        chk("post_rst_grant", 32'(ready_and_o), 32'h1);
        step();
        v_i = 2'b10;
        @(negedge clk);
        chk("post_rst_data0", 32'(data_o), 32'h60);
        step();
        v_i = 2'b00;
        @(negedge clk);
        chk("post_rst_data1", 32'(data_o), 32'h70);
        repeat (2) step();

        // Randomized traffic; sources hold until accepted.
        for (int c = 0; c < 10000; c++) begin
            for (int s = 0; s < N; s++) begin
                if (v_i[s] && acc_m[s]) v_i[s] = 1'b0;
                if (!v_i[s] && $urandom_range(0, 99) < 60) begin
                    v_i[s] = 1'b1;
                    data_i[s*W +: W] = 8'($urandom);
                end
            end
            ready_and_i = ($urandom_range(0, 3) != 0);
            step();
        end
        v_i = 2'b00;
        ready_and_i = 1'b1;
        repeat (4) step();
        chk("final_empty", 32'(v_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
